// File: rtl/regfile_scoreboard.sv
// Purpose: multi-ported register file with per-register busy (scoreboard) bits and write-through bypass.
// Latency: reads are combinational (0 cycles); write/reserve take effect on the rising edge; busy_count and all_idle are registered.
// Backpressure: none; every write and reserve is accepted on the edge where it is presented.
//
// Ports:
//   clk, rst                   - clock and synchronous active-high reset
//   read_addr1/2               - operand read addresses
//   read_data1/2, read_busy1/2 - operand data and pending-result flags (combinational)
//   write_addr/data, reg_write - single synchronous write port (clears busy)
//   reserve_addr, reserve      - marks a destination register busy
//   busy_count, all_idle       - registered count of busy registers and its zero flag
module regfile_scoreboard #(
   parameter int DATA_WIDTH = 4,
   parameter int ADDR_WIDTH = 2,
   parameter int ZERO_REG   = 0,
   parameter int BYPASS     = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] read_addr1,
   input  logic [ADDR_WIDTH-1:0] read_addr2,
   output logic [DATA_WIDTH-1:0] read_data1,
   output logic [DATA_WIDTH-1:0] read_data2,
   output logic                  read_busy1,
   output logic                  read_busy2,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  reg_write,
   input  logic [ADDR_WIDTH-1:0] reserve_addr,
   input  logic                  reserve,
   output logic [ADDR_WIDTH:0]   busy_count,
   output logic                  all_idle
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0]      busy;
   logic [DEPTH-1:0]      busy_nxt;
   logic [ADDR_WIDTH:0]   busy_count_q;

   logic wr_en;
   logic rsv_en;
   logic cnt_inc;
   logic cnt_dec;

   // Operations aimed at a hardwired-zero register are dropped entirely,
   // so they can neither store data nor disturb the busy accounting.
   assign wr_en  = reg_write && !((ZERO_REG != 0) && (write_addr == '0));
   assign rsv_en = reserve   && !((ZERO_REG != 0) && (reserve_addr == '0));

   always_comb begin
      busy_nxt = busy;
      if (wr_en)
         busy_nxt[write_addr] = 1'b0;
      // Reserve is applied after write so a same-address pair leaves the
      // register busy (back-to-back producer).
      if (rsv_en)
         busy_nxt[reserve_addr] = 1'b1;
   end

   // Count deltas are judged against the pre-edge busy vector.
   assign cnt_inc = rsv_en && !busy[reserve_addr];
   assign cnt_dec = wr_en && busy[write_addr] &&
                    !(rsv_en && (reserve_addr == write_addr));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            regs[i] <= '0;
         busy         <= '0;
         busy_count_q <= '0;
      end else begin
         if (wr_en)
            regs[write_addr] <= write_data;
         busy         <= busy_nxt;
         busy_count_q <= busy_count_q + (ADDR_WIDTH+1)'(cnt_inc)
                                      - (ADDR_WIDTH+1)'(cnt_dec);
      end
   end

   assign busy_count = busy_count_q;
   assign all_idle   = (busy_count_q == '0);

   // Two identical read ports, evaluated from a small array so the rule
   // is written once.
   logic [ADDR_WIDTH-1:0] ra [2];
   logic [DATA_WIDTH-1:0] rd [2];
   logic                  rb [2];

   assign ra[0] = read_addr1;
   assign ra[1] = read_addr2;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd[p] = regs[ra[p]];
         rb[p] = busy[ra[p]];
         if ((ZERO_REG != 0) && (ra[p] == '0)) begin
            rd[p] = '0;
            rb[p] = 1'b0;
         end else if ((BYPASS != 0) && reg_write && (write_addr == ra[p])) begin
            // Forwarded result is by definition no longer pending.
            rd[p] = write_data;
            rb[p] = 1'b0;
         end
      end
   end

   assign read_data1 = rd[0];
   assign read_data2 = rd[1];
   assign read_busy1 = rb[0];
   assign read_busy2 = rb[1];

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] read_addr1, read_addr2, write_addr, reserve_addr;
   logic [3:0] write_data;
   logic       reg_write, reserve;

   // a: defaults (BYPASS=1), b: BYPASS=0, z: ZERO_REG=1
   logic [3:0] rd1_a, rd2_a, rd1_b, rd2_b, rd1_z, rd2_z;
   logic       rb1_a, rb2_a, rb1_b, rb2_b, rb1_z, rb2_z;
   logic [2:0] cnt_a, cnt_b, cnt_z;
   logic       idle_a, idle_b, idle_z;

   always #5 clk = ~clk;

   regfile_scoreboard dut (
      .clk(clk), .rst(rst),
      .read_addr1(read_addr1), .read_addr2(read_addr2),
      .read_data1(rd1_a), .read_data2(rd2_a),
      .read_busy1(rb1_a), .read_busy2(rb2_a),
      .write_addr(write_addr), .write_data(write_data), .reg_write(reg_write),
      .reserve_addr(reserve_addr), .reserve(reserve),
      .busy_count(cnt_a), .all_idle(idle_a));

   regfile_scoreboard #(.BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst),
      .read_addr1(read_addr1), .read_addr2(read_addr2),
      .read_data1(rd1_b), .read_data2(rd2_b),
      .read_busy1(rb1_b), .read_busy2(rb2_b),
      .write_addr(write_addr), .write_data(write_data), .reg_write(reg_write),
      .reserve_addr(reserve_addr), .reserve(reserve),
      .busy_count(cnt_b), .all_idle(idle_b));

   regfile_scoreboard #(.ZERO_REG(1)) dut_z (
      .clk(clk), .rst(rst),
      .read_addr1(read_addr1), .read_addr2(read_addr2),
      .read_data1(rd1_z), .read_data2(rd2_z),
      .read_busy1(rb1_z), .read_busy2(rb2_z),
      .write_addr(write_addr), .write_data(write_data), .reg_write(reg_write),
      .reserve_addr(reserve_addr), .reserve(reserve),
      .busy_count(cnt_z), .all_idle(idle_z));

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic pop_chk(input logic [31:0] obs);
      exp_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_underflow: observed %0h with no expected entry", obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
         end
      end
   endtask

   // advance one rising edge, then settle away from it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; reg_write = 1'b0; reserve = 1'b0;
      read_addr1 = '0; read_addr2 = '0; write_addr = '0; reserve_addr = '0;
      write_data = '0;

      // ---- reset state
      step();
      rst = 1'b0;
      for (int a = 0; a < 4; a++) begin
         read_addr1 = 2'(a); read_addr2 = 2'(a);
         push("rst_rd1", 0); push("rst_rb1", 0); push("rst_rd2", 0); push("rst_rb2", 0);
         push("rst_nb_rd1", 0); push("rst_z_rb2", 0);
         #1;
         pop_chk(rd1_a); pop_chk(rb1_a); pop_chk(rd2_a); pop_chk(rb2_a);
         pop_chk(rd1_b); pop_chk(rb2_z);
      end
      push("rst_cnt", 0); push("rst_idle", 1); push("rst_nb_cnt", 0); push("rst_z_idle", 1);
      pop_chk(cnt_a); pop_chk(idle_a); pop_chk(cnt_b); pop_chk(idle_z);

      // ---- bypass vs. no bypass: write reg2 = A
      reg_write = 1'b1; write_addr = 2'd2; write_data = 4'hA;
      read_addr1 = 2'd2; read_addr2 = 2'd1;
      push("byp_rd1", 'hA); push("byp_rb1", 0); push("byp_rd2_other", 0); push("nb_rd1_old", 0);
      #1;
      pop_chk(rd1_a); pop_chk(rb1_a); pop_chk(rd2_a); pop_chk(rd1_b);
      step();
      reg_write = 1'b0;
      push("byp_rd1_after", 'hA); push("nb_rd1_after", 'hA);
      #1;
      pop_chk(rd1_a); pop_chk(rd1_b);

      // ---- reserve reg3, then write it back
      reserve = 1'b1; reserve_addr = 2'd3; read_addr1 = 2'd3;
      push("rsv_same_cycle_rb1", 0);
      #1;
      pop_chk(rb1_a);
      step();
      reserve = 1'b0;
      push("rsv_rb1", 1); push("rsv_cnt", 1); push("rsv_idle", 0); push("rsv_z_cnt", 1);
      #1;
      pop_chk(rb1_a); pop_chk(cnt_a); pop_chk(idle_a); pop_chk(cnt_z);
      reg_write = 1'b1; write_addr = 2'd3; write_data = 4'h5;
      push("wb_byp_rd1", 'h5); push("wb_byp_rb1", 0); push("wb_nb_rd1", 0); push("wb_nb_rb1", 1);
      #1;
      pop_chk(rd1_a); pop_chk(rb1_a); pop_chk(rd1_b); pop_chk(rb1_b);
      step();
      reg_write = 1'b0;
      push("wb_nb_rd1_after", 'h5); push("wb_nb_rb1_after", 0);
      push("wb_cnt", 0); push("wb_idle", 1); push("wb_nb_cnt", 0);
      #1;
      pop_chk(rd1_b); pop_chk(rb1_b); pop_chk(cnt_a); pop_chk(idle_a); pop_chk(cnt_b);

      // ---- zero register: write F and reserve reg0 together
      reg_write = 1'b1; write_addr = 2'd0; write_data = 4'hF;
      reserve = 1'b1; reserve_addr = 2'd0; read_addr1 = 2'd0;
      push("z_rd1_during", 0); push("z_rb1_during", 0); push("a_rd1_byp_reg0", 'hF);
      #1;
      pop_chk(rd1_z); pop_chk(rb1_z); pop_chk(rd1_a);
      step();
      reg_write = 1'b0; reserve = 1'b0;
      push("z_rd1", 0); push("z_rb1", 0); push("z_cnt", 0); push("z_idle", 1);
      push("a_rd1_reg0", 'hF); push("a_rb1_reg0", 1); push("a_cnt_reg0", 1);
      #1;
      pop_chk(rd1_z); pop_chk(rb1_z); pop_chk(cnt_z); pop_chk(idle_z);
      pop_chk(rd1_a); pop_chk(rb1_a); pop_chk(cnt_a);
      // release reg0 on the non-zero instances
      reg_write = 1'b1; write_addr = 2'd0; write_data = 4'h0;
      step();
      reg_write = 1'b0;
      push("clr0_cnt", 0); push("clr0_nb_cnt", 0);
      #1;
      pop_chk(cnt_a); pop_chk(cnt_b);

      // ---- write + reserve reg1 on the same edge (idle, then busy)
      reg_write = 1'b1; write_addr = 2'd1; write_data = 4'h6;
      reserve = 1'b1; reserve_addr = 2'd1; read_addr1 = 2'd1;
      step();
      write_data = 4'h9;
      push("wr_rsv_rd1", 'h6); push("wr_rsv_rb1", 1); push("wr_rsv_cnt", 1);
      push("wr_rsv_nb_cnt", 1); push("wr_rsv_z_cnt", 1);
      #1;
      pop_chk(rd1_b); pop_chk(rb1_b); pop_chk(cnt_a); pop_chk(cnt_b); pop_chk(cnt_z);
      // second write+reserve still in progress: bypass sees 9, not busy
      push("wr_rsv2_byp_rd1", 'h9); push("wr_rsv2_byp_rb1", 0); push("wr_rsv2_nb_rb1", 1);
      #1;
      pop_chk(rd1_a); pop_chk(rb1_a); pop_chk(rb1_b);
      step();
      reg_write = 1'b0; reserve = 1'b0;
      push("wr_rsv2_rd1", 'h9); push("wr_rsv2_rb1", 1); push("wr_rsv2_cnt", 1); push("wr_rsv2_z_cnt", 1);
      #1;
      pop_chk(rd1_a); pop_chk(rb1_a); pop_chk(cnt_a); pop_chk(cnt_z);

      // ---- reserve every register, one per cycle
      for (int a = 0; a < 4; a++) begin
         reserve = 1'b1; reserve_addr = 2'(a);
         step();
      end
      reserve = 1'b0;
      read_addr1 = 2'd0; read_addr2 = 2'd3;
      push("full_cnt", 4); push("full_idle", 0); push("full_nb_cnt", 4);
      push("full_z_cnt", 3); push("full_z_rb1_reg0", 0); push("full_z_rb2", 1); push("full_rb1", 1);
      #1;
      pop_chk(cnt_a); pop_chk(idle_a); pop_chk(cnt_b);
      pop_chk(cnt_z); pop_chk(rb1_z); pop_chk(rb2_z); pop_chk(rb1_a);

      // ---- reset with a concurrent write of 7 to reg2
      rst = 1'b1; reg_write = 1'b1; write_addr = 2'd2; write_data = 4'h7; read_addr1 = 2'd2;
      push("rstw_byp_rd1", 'h7); push("rstw_byp_rb1", 0); push("rstw_nb_rd1", 'hA); push("rstw_nb_rb1", 1);
      #1;
      pop_chk(rd1_a); pop_chk(rb1_a); pop_chk(rd1_b); pop_chk(rb1_b);
      step();
      rst = 1'b0; reg_write = 1'b0;
      for (int a = 0; a < 4; a++) begin
         read_addr1 = 2'(a); read_addr2 = 2'(a);
         push("rstw_rd1", 0); push("rstw_rb1", 0); push("rstw_nb_rd2", 0);
         push("rstw_nb_rb2", 0); push("rstw_z_rd1", 0);
         #1;
         pop_chk(rd1_a); pop_chk(rb1_a); pop_chk(rd2_b); pop_chk(rb2_b); pop_chk(rd1_z);
      end
      push("rstw_cnt", 0); push("rstw_idle", 1); push("rstw_nb_cnt", 0);
      push("rstw_z_cnt", 0); push("rstw_z_idle", 1);
      pop_chk(cnt_a); pop_chk(idle_a); pop_chk(cnt_b); pop_chk(cnt_z); pop_chk(idle_z);

      // every expectation pushed must have been consumed
      n_checks++;
      assert (exp_q.size() == 0) else begin
         n_fail++;
         $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
